codificador_secded: RTL and testbench

CODIFICADOR_SECDED -- requirements
Module: codificador_secded

---
 rtl/codificador_pkg.sv | 38 +++
 rtl/codificador_secded_fifo_2x4.sv | 68 ++++++
 rtl/codificador_secded.sv | 83 ++++++++
 tb/tb_codificador_secded.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/codificador_pkg.sv
// Shared definitions for the SECDED (8,4) encoder: codeword bit positions,
// input-buffer occupancy states and the single parity definition, which the
// encoder and any decoder-side checker both call.
package codificador_pkg;

  // Codeword bit positions
  localparam int unsigned POS_P1 = 0;
  localparam int unsigned POS_P2 = 1;
  localparam int unsigned POS_D0 = 2;
  localparam int unsigned POS_P3 = 3;
  localparam int unsigned POS_D1 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;
  localparam int unsigned POS_PT = 7;

  // Occupancy of the 2-entry input buffer
  typedef enum logic [1:0] {
    VACIO = 2'd0,
    UNO   = 2'd1,
    DOS   = 2'd2
  } estado_fifo_t;

  // Hamming(7,4) plus an overall even-parity bit
  function automatic logic [7:0] calc_secded(input logic [3:0] d);
    logic [7:0] w;
    w         = '0;
    w[POS_D0] = d[0];
    w[POS_D1] = d[1];
    w[POS_D2] = d[2];
    w[POS_D3] = d[3];
    w[POS_P1] = d[0] ^ d[1] ^ d[3];
    w[POS_P2] = d[0] ^ d[2] ^ d[3];
    w[POS_P3] = d[1] ^ d[2] ^ d[3];
    w[POS_PT] = ^w[6:0];
    return w;
  endfunction

endpackage

// File: rtl/codificador_secded_fifo_2x4.sv
// fifo_2x4: two-entry, 4-bit FIFO with an explicit occupancy FSM.
// listo_o is registered from the next occupancy, so it does not look ahead
// at a same-cycle pop: a full buffer refuses data for that whole cycle.
module fifo_2x4
  import codificador_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [3:0] dato_i,
  output logic [3:0] cabeza_o,
  output logic       vacio_o,
  output logic       listo_o
);

  estado_fifo_t estado_q, estado_d;
  logic [3:0]   mem_q [2];
  logic         wr_q, rd_q;
  logic         listo_q;
  logic         push_ok, pop_ok;

  assign push_ok = push_i && (estado_q != DOS);
  assign pop_ok  = pop_i  && (estado_q != VACIO);

  // Next occupancy: push and pop on the same edge cancel out
  always_comb begin
    estado_d = estado_q;
    if (push_ok && !pop_ok) begin
      case (estado_q)
        VACIO:   estado_d = UNO;
        UNO:     estado_d = DOS;
        default: estado_d = estado_q;
      endcase
    end else if (pop_ok && !push_ok) begin
      case (estado_q)
        DOS:     estado_d = UNO;
        UNO:     estado_d = VACIO;
        default: estado_d = estado_q;
      endcase
    end
  end

  // Occupancy, pointers and registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= VACIO;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      listo_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      listo_q  <= (estado_d != DOS);
      if (push_ok) wr_q <= ~wr_q;
      if (pop_ok)  rd_q <= ~rd_q;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= dato_i;
  end

  assign cabeza_o = mem_q[rd_q];
  assign vacio_o  = (estado_q == VACIO);
  assign listo_o  = listo_q;

endmodule

// File: rtl/codificador_secded.sv
// codificador_secded: streaming SECDED (8,4) encoder with valid/ready on
// both sides, a 2-entry input buffer, a registered output word and a
// delivered-word counter.
// Optional macro INYECCION_ERROR_EN adds the mascara_error port, XORed into
// the codeword when the output register loads.
module codificador_secded
  import codificador_pkg::*;
#(
  parameter int unsigned ANCHO_CONT = 8
) (
  input  logic                  reloj,
  input  logic                  reinicio_n,
  input  logic [3:0]            dato,
  input  logic                  dato_valido,
  output logic                  dato_listo,
  output logic [7:0]            palabra,
  output logic                  palabra_valida,
  input  logic                  palabra_lista,
`ifdef INYECCION_ERROR_EN
  input  logic [7:0]            mascara_error,
`endif
  output logic [ANCHO_CONT-1:0] contador
);

  logic [3:0]            cabeza;
  logic                  fifo_vacio, fifo_listo;
  logic                  push, pop;
  logic [7:0]            mascara;
  logic [7:0]            palabra_q, palabra_d;
  logic                  valida_q;
  logic [ANCHO_CONT-1:0] contador_q;

  assign push = dato_valido && fifo_listo;
  // Loading the output register is what removes the head from the buffer
  assign pop  = !fifo_vacio && (!valida_q || palabra_lista);

`ifdef INYECCION_ERROR_EN
  assign mascara = mascara_error;
`else
  assign mascara = '0;
`endif

  assign palabra_d = calc_secded(cabeza) ^ mascara;

  fifo_2x4 u_fifo (
    .clk      (reloj),
    .rst_n    (reinicio_n),
    .push_i   (push),
    .pop_i    (pop),
    .dato_i   (dato),
    .cabeza_o (cabeza),
    .vacio_o  (fifo_vacio),
    .listo_o  (fifo_listo)
  );

  // Output register: load on pop, drop valid when consumed with nothing behind
  always_ff @(posedge reloj or negedge reinicio_n) begin
    if (!reinicio_n) begin
      palabra_q <= '0;
      valida_q  <= 1'b0;
    end else if (pop) begin
      palabra_q <= palabra_d;
      valida_q  <= 1'b1;
    end else if (palabra_lista) begin
      valida_q  <= 1'b0;
    end
  end

  // Count every delivered codeword, wrapping naturally
  always_ff @(posedge reloj or negedge reinicio_n) begin
    if (!reinicio_n) begin
      contador_q <= '0;
    end else if (valida_q && palabra_lista) begin
      contador_q <= contador_q + ANCHO_CONT'(1);
    end
  end

  assign dato_listo     = fifo_listo;
  assign palabra        = palabra_q;
  assign palabra_valida = valida_q;
  assign contador       = contador_q;

endmodule

// File: tb/tb_codificador_secded.sv
// Scoreboard bench for codificador_secded: accepted nibbles push their
// expected codeword into a queue, a monitor pops and compares on each
// delivery. The reference encoder is written from Hamming positions.
module tb_codificador_secded;
`ifdef INYECCION_ERROR_EN
  import codificador_pkg::*;
`endif

  logic       reloj = 1'b0;
  logic       reinicio_n;
  logic [3:0] dato;
  logic       dato_valido, palabra_lista;
  logic       dato_listo, palabra_valida;
  logic [7:0] palabra, mascara;
  logic [7:0] contador;
  logic       listo4, valida4;
  logic [7:0] palabra4;
  logic [3:0] contador4;

  int checks   = 0;
  int failures = 0;
  logic [7:0]  esperado_q [$];
  logic [7:0]  entregadas [$];
  int unsigned entregas = 0;
  logic        prev_valida, prev_lista;
  logic [7:0]  prev_palabra;

  always #5 reloj = ~reloj;

  codificador_secded dut (
    .reloj(reloj), .reinicio_n(reinicio_n), .dato(dato), .dato_valido(dato_valido),
    .dato_listo(dato_listo), .palabra(palabra), .palabra_valida(palabra_valida),
    .palabra_lista(palabra_lista),
`ifdef INYECCION_ERROR_EN
    .mascara_error(mascara),
`endif
    .contador(contador)
  );

  codificador_secded #(.ANCHO_CONT(4)) dut4 (
    .reloj(reloj), .reinicio_n(reinicio_n), .dato(dato), .dato_valido(dato_valido),
    .dato_listo(listo4), .palabra(palabra4), .palabra_valida(valida4),
    .palabra_lista(palabra_lista),
`ifdef INYECCION_ERROR_EN
    .mascara_error(mascara),
`endif
    .contador(contador4)
  );

  // Reference: data at Hamming positions 3,5,6,7; parity j covers positions with bit j set
  function automatic logic [7:0] modelo(input logic [3:0] d);
    logic [7:0]  w;
    int unsigned posd [4];
    logic        par;
    posd = '{3, 5, 6, 7};
    w    = '0;
    for (int i = 0; i < 4; i++) w[posd[i]-1] = d[i];
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int p = 1; p < 8; p++)
        if (((p >> j) & 1) == 1 && p != (1 << j)) par ^= w[p-1];
      w[(1 << j) - 1] = par;
    end
    w[7] = ^w[6:0];
    return w;
  endfunction

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h requerido=%0h", nombre, act, req);
    end
  endtask

  // Stimulus side of the scoreboard
  always @(negedge reloj) begin
    if (reinicio_n === 1'b1 && dato_valido && dato_listo)
      esperado_q.push_back(modelo(dato) ^ mascara);
  end

  // Monitor: delivery order/value, hold-while-stalled, counters
  always @(negedge reloj) begin
    if (reinicio_n !== 1'b1) begin
      prev_valida = 1'b0;
      prev_lista  = 1'b0;
    end else begin
      if (prev_valida && !prev_lista) begin
        chk("estable_valida", {31'b0, palabra_valida}, 1);
        chk("estable_palabra", {24'b0, palabra}, {24'b0, prev_palabra});
      end
      chk("contador", {24'b0, contador}, {24'b0, entregas[7:0]});
      chk("contador4", {28'b0, contador4}, {28'b0, entregas[3:0]});
      if (palabra_valida && palabra_lista) begin
        if (esperado_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL palabra_inesperada actual=%0h requerido=ninguna", palabra);
        end else begin
          chk("palabra", {24'b0, palabra}, {24'b0, esperado_q.pop_front()});
        end
        entregadas.push_back(palabra);
        entregas++;
      end
      prev_valida  = palabra_valida;
      prev_lista   = palabra_lista;
      prev_palabra = palabra;
    end
  end

  task automatic aplicar_reset(input string e);
    reinicio_n = 1'b0;
    #1;
    chk({e, "_palabra"}, {24'b0, palabra}, 0);
    chk({e, "_valida"}, {31'b0, palabra_valida}, 0);
    chk({e, "_listo"}, {31'b0, dato_listo}, 0);
    chk({e, "_contador"}, {24'b0, contador}, 0);
    esperado_q.delete();
    entregas = 0;
    repeat (2) @(posedge reloj);
    #1 reinicio_n = 1'b1;
    #1 chk({e, "_listo_tras_soltar"}, {31'b0, dato_listo}, 0);
    @(posedge reloj); #1;
    chk({e, "_listo_primer_flanco"}, {31'b0, dato_listo}, 1);
  endtask

  task automatic ciclos(input int n);
    repeat (n) begin @(posedge reloj); #1; end
  endtask

  // Fill: first word in output register, buffer full (lista held low)
  task automatic llenar_tres();
    palabra_lista = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      dato = i[3:0]; dato_valido = 1'b1;
      ciclos(1);
    end
  endtask

`ifdef INYECCION_ERROR_EN
  task automatic inyectar(input logic [7:0] m, input logic [7:0] req,
                          input logic simple, input logic doble);
    logic [7:0] ref_w;
    logic [2:0] sind;
    logic       glob;
    mascara = m; palabra_lista = 1'b1;
    dato = 4'b1010; dato_valido = 1'b1;
    ciclos(1);
    dato_valido = 1'b0;
    ciclos(1);
    chk("inyeccion_palabra", {24'b0, palabra}, {24'b0, req});
    ref_w = calc_secded({palabra[6], palabra[5], palabra[4], palabra[2]});
    sind  = {ref_w[3] ^ palabra[3], ref_w[1] ^ palabra[1], ref_w[0] ^ palabra[0]};
    glob  = ^palabra;
    chk("decod_simple", {31'b0, glob}, {31'b0, simple});
    chk("decod_doble", {31'b0, (sind != 3'b0) && !glob}, {31'b0, doble});
    ciclos(2);
    mascara = 8'h00;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=sin_fin requerido=fin");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int run, maxrun;
    dato = 4'h0; dato_valido = 1'b0; palabra_lista = 1'b0; mascara = 8'h00;
    prev_valida = 1'b0; prev_lista = 1'b0; prev_palabra = 8'h00;
    aplicar_reset("reset_ini");

    // Single word, latency and clear-on-consume
    palabra_lista = 1'b1;
    dato = 4'b1010; dato_valido = 1'b1;
    ciclos(1);
    dato_valido = 1'b0;
    chk("latencia_aun_no", {31'b0, palabra_valida}, 0);
    ciclos(1);
    chk("latencia_valida", {31'b0, palabra_valida}, 1);
    chk("palabra_1010", {24'b0, palabra}, 32'hD2);
    ciclos(1);
    chk("contador_uno", {24'b0, contador}, 1);
    chk("valida_se_borra", {31'b0, palabra_valida}, 0);

    // All nibbles back to back
    base = entregadas.size();
    run = 0; maxrun = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin dato = i[3:0]; dato_valido = 1'b1; end
      else dato_valido = 1'b0;
      ciclos(1);
      if (palabra_valida) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("rafaga_consecutiva", maxrun, 16);
    chk("rafaga_0000", {24'b0, entregadas[base]}, 32'h00);
    chk("rafaga_0001", {24'b0, entregadas[base+1]}, 32'h87);
    chk("rafaga_1111", {24'b0, entregadas[base+15]}, 32'hFF);
    chk("contador_17", {24'b0, contador}, 17);
    chk("contador4_vuelta", {28'b0, contador4}, 1);

    // Backpressure: buffer full, fourth word must stall
    base = entregadas.size();
    llenar_tres();
    chk("lleno_listo", {31'b0, dato_listo}, 0);
    chk("lleno_valida", {31'b0, palabra_valida}, 1);
    chk("lleno_cabeza", {24'b0, palabra}, {24'b0, modelo(4'd1)});
    dato = 4'd4;
    ciclos(3);
    chk("bloqueo_listo", {31'b0, dato_listo}, 0);
    dato_valido = 1'b0; palabra_lista = 1'b1;
    ciclos(5);
    chk("orden_n", entregadas.size() - base, 3);
    chk("orden_1", {24'b0, entregadas[base]}, {24'b0, modelo(4'd1)});
    chk("orden_2", {24'b0, entregadas[base+1]}, {24'b0, modelo(4'd2)});
    chk("orden_3", {24'b0, entregadas[base+2]}, {24'b0, modelo(4'd3)});

`ifdef INYECCION_ERROR_EN
    inyectar(8'h01, 8'hD3, 1'b1, 1'b0);
    inyectar(8'h03, 8'hD1, 1'b0, 1'b1);
`endif

    // Reset while full with a valid output: nothing stale afterwards
    llenar_tres();
    dato_valido = 1'b0;
    aplicar_reset("reset_lleno");
    palabra_lista = 1'b1;
    ciclos(5);
    chk("sin_palabra_vieja", entregas, 0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      dato          = 4'($urandom_range(0, 15));
      dato_valido   = ($urandom_range(0, 3) != 0);
      palabra_lista = ($urandom_range(0, 2) != 0);
      ciclos(1);
    end
    dato_valido = 1'b0; palabra_lista = 1'b1;
    ciclos(6);
    chk("cola_vacia", esperado_q.size(), 0);
    chk("salida_drenada", {31'b0, palabra_valida}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
